// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg
// Shared definitions for the LED pattern controller: channel mode encoding,
// register offsets inside a slot, the global slot number and a small helper
// that tells whether a mode uses the channel counter.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    // Global slot registers
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    // Channel slot registers
    localparam logic [1:0] REG_MODE   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_DUTY   = 2'd2;
    localparam logic [1:0] REG_COUNT  = 2'd3;

    localparam int SLOT_GLOBAL = 0;

    // True for the modes that advance the counter (BLINK and PWM).
    function automatic logic mode_runs(input logic [1:0] mode);
        return (mode == MODE_BLINK) || (mode == MODE_PWM);
    endfunction

endpackage

// File: rtl/led_channel.sv
// led_channel
// One LED channel: period counter, blink phase and the registered LED bit.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              global enable; when low counter/phase held at 0, led forced 0
//   mode            channel mode (OFF/ON/BLINK/PWM)
//   period, duty    channel PERIOD and DUTY register values
//   clear           pulse from a MODE/PERIOD write; restarts counter and phase
//   count           live counter value (for the COUNT register)
//   led             registered LED drive
module led_channel
    import led_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             led
);

    logic [CNT_W-1:0] cnt_r;
    logic             phase_r;
    logic             led_r;
    logic             run_s;
    logic             wrap_s;
    logic             led_next_s;

    assign run_s  = en && mode_runs(mode);
    // Counter only ever lives in 0..period because every PERIOD write clears it,
    // so equality is enough to detect the end of a frame.
    assign wrap_s = (cnt_r == period);

    // LED value derived from current registered state.
    always_comb begin
        led_next_s = 1'b0;
        if (!en) begin
            led_next_s = 1'b0;
        end else begin
            case (mode)
                MODE_OFF:   led_next_s = 1'b0;
                MODE_ON:    led_next_s = 1'b1;
                MODE_BLINK: led_next_s = phase_r;
                MODE_PWM:   led_next_s = (cnt_r < duty);
                default:    led_next_s = 1'b0;
            endcase
        end
    end

    // Frame counter and blink phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            phase_r <= 1'b0;
        end else if (clear || !run_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            phase_r <= 1'b0;
        end else if (wrap_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end

    // Registered LED output, one cycle behind the counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r <= 1'b0;
        end else begin
            led_r <= led_next_s;
        end
    end

    assign count = cnt_r;
    assign led   = led_r;

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
// Avalon-MM slave driving N_CH LEDs as off / on / blink / PWM.
// Address: [ADDR_W-1:2] slot, [1:0] register. Slot 0 = CTRL/STATUS,
// slot c+1 = channel c (MODE, PERIOD, DUTY, COUNT). Unmapped reads return 0.
// Ports:
//   CLOCK_50       clock
//   RESET          asynchronous active-high reset
//   avs_address    word address
//   avs_write      write strobe, avs_writedata write data
//   avs_read       read strobe
//   avs_readdata   read data, registered, valid one edge after the read
//   led            registered LED drives, bit c = channel c
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int CNT_W      = 32,
    parameter int RST_PERIOD = 24_999_999,
    localparam int ADDR_W    = $clog2(N_CH + 1) + 2
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic [N_CH-1:0]   led
);

    localparam int SLOT_W = ADDR_W - 2;

    logic [SLOT_W-1:0]          slot_s;
    logic [1:0]                 reg_s;
    logic                       en_r;
    logic [1:0]                 mode_r   [N_CH];
    logic [CNT_W-1:0]           period_r [N_CH];
    logic [CNT_W-1:0]           duty_r   [N_CH];
    logic [CNT_W-1:0]           count_s  [N_CH];
    logic [N_CH-1:0]            clear_s;
    logic [N_CH-1:0]            led_s;
    logic [N_CH-1:0][31:0]      ch_word_s;
    logic [31:0]                glob_word_s;
    logic [31:0]                rd_s;
    logic [31:0]                readdata_r;

    assign slot_s = avs_address[ADDR_W-1:2];
    assign reg_s  = avs_address[1:0];

    // Register file writes; RO and unmapped locations fall through the defaults.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            en_r <= 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                mode_r[c]   <= 2'd0;
                period_r[c] <= CNT_W'(RST_PERIOD);
                duty_r[c]   <= {CNT_W{1'b0}};
            end
        end else if (avs_write) begin
            if ((slot_s == SLOT_W'(SLOT_GLOBAL)) && (reg_s == REG_CTRL)) begin
                en_r <= avs_writedata[0];
            end
            for (int c = 0; c < N_CH; c++) begin
                if (slot_s == SLOT_W'(c + 1)) begin
                    case (reg_s)
                        REG_MODE:   mode_r[c]   <= avs_writedata[1:0];
                        REG_PERIOD: period_r[c] <= avs_writedata[CNT_W-1:0];
                        REG_DUTY:   duty_r[c]   <= avs_writedata[CNT_W-1:0];
                        default:    ;
                    endcase
                end
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [31:0] word_s;

        // MODE and PERIOD writes restart the pattern on the same edge.
        assign clear_s[c] = avs_write && (slot_s == SLOT_W'(c + 1)) &&
                            ((reg_s == REG_MODE) || (reg_s == REG_PERIOD));

        // Read word contributed by this channel (zero unless addressed).
        always_comb begin
            word_s = 32'd0;
            if (slot_s == SLOT_W'(c + 1)) begin
                case (reg_s)
                    REG_MODE:   word_s[1:0]       = mode_r[c];
                    REG_PERIOD: word_s[CNT_W-1:0] = period_r[c];
                    REG_DUTY:   word_s[CNT_W-1:0] = duty_r[c];
                    REG_COUNT:  word_s[CNT_W-1:0] = count_s[c];
                    default:    word_s            = 32'd0;
                endcase
            end else begin
                word_s = 32'd0;
            end
        end

        assign ch_word_s[c] = word_s;

        led_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk    (CLOCK_50),
            .rst    (RESET),
            .en     (en_r),
            .mode   (mode_r[c]),
            .period (period_r[c]),
            .duty   (duty_r[c]),
            .clear  (clear_s[c]),
            .count  (count_s[c]),
            .led    (led_s[c])
        );
    end

    // Read word for the global slot.
    always_comb begin
        glob_word_s = 32'd0;
        if (slot_s == SLOT_W'(SLOT_GLOBAL)) begin
            case (reg_s)
                REG_CTRL:   glob_word_s[0]      = en_r;
                REG_STATUS: glob_word_s[N_CH-1:0] = led_s;
                default:    glob_word_s         = 32'd0;
            endcase
        end else begin
            glob_word_s = 32'd0;
        end
    end

    // At most one source is non-zero, so OR-ing them forms the read mux.
    always_comb begin
        rd_s = glob_word_s;
        for (int c = 0; c < N_CH; c++) begin
            rd_s = rd_s | ch_word_s[c];
        end
    end

    // Read data register: captures pre-write state, holds until the next read.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            readdata_r <= 32'd0;
        end else if (avs_read) begin
            readdata_r <= rd_s;
        end
    end

    assign avs_readdata = readdata_r;
    assign led          = led_s;

endmodule
